hs_skid_reg: RTL and testbench
==============================

HS_SKID_REG -- requirements
Module: hs_skid_reg

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the payload in bits; legal range 1..1024.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din_data  input  DATA_WIDTH  upstream payload.
REQ-005 Port: din_vld  input  1  upstream payload valid.
REQ-006 Port: din_rd  output  1  block can accept upstream payload.
REQ-007 Port: dout_data  output  DATA_WIDTH  downstream payload.
REQ-008 Port: dout_vld  output  1  downstream payload valid.
REQ-009 Port: dout_rd  input  1  downstream accepts payload.
REQ-010 Port: occupancy  output  2  number of words held: 0, 1 or 2.

Function
REQ-011 A transfer SHALL occur on a port in a cycle where vld and rd are both 1 at the rising clk edge.
REQ-012 The block SHALL hold two registers, main and skid, and a state machine with states EMPTY, ONE and FULL.
REQ-013 Outputs SHALL come only from registers: dout_data = main, dout_vld = (state != EMPTY), din_rd = (state != FULL) while rst_n = 1, occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-014 There SHALL be no combinational path from dout_rd or din_vld to any output.
REQ-015 EMPTY: on din_vld, main <= din_data and state -> ONE; otherwise the state is held.
REQ-016 ONE, input only (din_vld=1, dout_rd=0): skid <= din_data and state -> FULL.
REQ-017 ONE, output only (din_vld=0, dout_rd=1): state -> EMPTY; main keeps its value.
REQ-018 ONE, simultaneous input and output: main <= din_data and state stays ONE, giving one transfer per clk in both directions.
REQ-019 ONE, neither input nor output: everything is held.
REQ-020 FULL: din_rd = 0, so din_vld is ignored; on dout_rd, main <= skid and state -> ONE; otherwise everything is held.
REQ-021 Latency from an accepted input word to dout_vld SHALL be 1 clk when the block is empty.
REQ-022 Sustained throughput SHALL be 1 word/clk when dout_rd is held at 1.
REQ-023 Order SHALL be preserved, with no loss or duplication under any vld/rd pattern.
REQ-024 While dout_vld = 1 and dout_rd = 0, dout_data SHALL stay stable.
REQ-025 Payload SHALL pass through bit-exact with no width conversion.

Reset
REQ-026 rst_n = 0 SHALL immediately, without waiting for clk, force: state = EMPTY, main = 0, skid = 0, dout_vld = 0, din_rd = 0, occupancy = 0.
REQ-027 Reset asserted mid-operation SHALL discard all held words, including a FULL state.
REQ-028 After rst_n rises, din_rd SHALL be 1 and the first accepted word SHALL appear on dout in the next cycle.
REQ-029 rst_n deassertion SHALL be synchronised externally; the block makes no recovery/removal assumption beyond that.

Structure
REQ-030 The state encoding (EMPTY=0, ONE=1, FULL=2, 2 bits) SHALL live in shared package hs_pkg with the occupancy width constant, for reuse by handshaked FIFOs.
REQ-031 The block SHALL be one module with no sub-modules; a generic register with enable is not instantiated, so that reset polarity stays local.
REQ-032 Chaining N instances SHALL form an N-stage pipeline with registered backpressure.

Verification
REQ-033 Reset then idle: rst_n=0 for 3 clk, then 1 -> occupancy=0, dout_vld=0, din_rd=1, dout_data=0.
REQ-034 Single word: din 0xA5 accepted with dout_rd=1 -> dout_vld=1, dout_data=0xA5 the next cycle, then EMPTY.
REQ-035 Streaming: 0x01..0x10 offered back to back with dout_rd=1 -> 16 words out in order on 16 consecutive cycles, occupancy=1 throughout.
REQ-036 Backpressure: dout_rd=0, offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, din_rd=0 and occupancy=2; 0x33 held upstream; dout_rd=1 -> output 0x11, 0x22, 0x33 with no gap.
REQ-037 Random: random din_vld/dout_rd, 10000 words -> scoreboard exact order, dout_data stable while stalled, occupancy always ≤ 2.
REQ-038 Reset in FULL: assert rst_n=0 asynchronously mid-cycle -> outputs reach reset values before the next clk edge; no old word emitted after release.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared handshake definitions: state encoding and occupancy width for
// valid/ready style storage blocks (skid registers, small FIFOs).
package hs_pkg;

  // Occupancy is reported directly from the state encoding, so the encoding
  // value equals the number of words held.
  localparam int unsigned OccWidth = 2;

  typedef enum logic [OccWidth-1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hs_skid_reg.sv
// Two-entry skid register. All outputs come from flops (din_rd is only
// additionally qualified by reset), so chaining instances breaks both the
// data path and the backpressure path at every stage.
module hs_skid_reg
  import hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_vld,
  input  logic                  dout_rd,
  output logic [OccWidth-1:0]   occupancy
);

  hs_state_e             state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  // Occupancy FSM with the main (output) and skid (overflow) registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (din_vld) begin
            main_q  <= din_data;
            state_q <= StOne;
          end
        end
        StOne: begin
          case ({din_vld, dout_rd})
            2'b10: begin
              skid_q  <= din_data;
              state_q <= StFull;
            end
            // main keeps its stale value; dout_vld masks it.
            2'b01: state_q <= StEmpty;
            2'b11: main_q  <= din_data;
            default: ;
          endcase
        end
        StFull: begin
          // din_rd is low here, so any offered input is ignored.
          if (dout_rd) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  assign dout_data = main_q;
  assign dout_vld  = (state_q != StEmpty);
  assign din_rd    = rst_n & (state_q != StFull);
  assign occupancy = state_q;

endmodule

// File: tb/tb_hs_skid_reg.sv
// Directed and randomised checks for hs_skid_reg with a queue scoreboard.
module tb_hs_skid_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] din_data;
  logic       din_vld;
  logic       din_rd;
  logic [7:0] dout_data;
  logic       dout_vld;
  logic       dout_rd;
  logic [1:0] occupancy;

  int n_checks;
  int n_pass;

  hs_skid_reg #(
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_data (din_data),
    .din_vld  (din_vld),
    .din_rd   (din_rd),
    .dout_data(dout_data),
    .dout_vld (dout_vld),
    .dout_rd  (dout_rd),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       prev_stall;
  logic [7:0] prev_data;
  int         words_out;
  int         cycles;
  logic       in_fire;
  logic       out_fire;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    din_vld  = 1'b0;
    din_data = 8'h00;
    dout_rd  = 1'b0;

    // Reset then idle.
    repeat (3) step();
    check("rst_din_rd_low", din_rd, 0);
    check("rst_occ", occupancy, 0);
    rst_n = 1'b1;
    #1;
    check("idle_occ", occupancy, 0);
    check("idle_vld", dout_vld, 0);
    check("idle_din_rd", din_rd, 1);
    check("idle_data", dout_data, 0);

    // Single word with downstream ready.
    din_vld  = 1'b1;
    din_data = 8'hA5;
    dout_rd  = 1'b1;
    step();
    check("single_vld", dout_vld, 1);
    check("single_data", dout_data, 8'hA5);
    check("single_occ", occupancy, 1);
    din_vld = 1'b0;
    step();
    check("single_empty_vld", dout_vld, 0);
    check("single_empty_occ", occupancy, 0);

    // Streaming 0x01..0x10 at one word per clock.
    for (int i = 1; i <= 16; i++) begin
      din_vld  = 1'b1;
      din_data = 8'(i);
      step();
      check("stream_data", dout_data, i);
      check("stream_vld", dout_vld, 1);
      check("stream_occ", occupancy, 1);
    end
    din_vld = 1'b0;
    step();
    check("stream_drain_occ", occupancy, 0);

    // Backpressure fills main then skid; third word waits upstream.
    dout_rd  = 1'b0;
    din_vld  = 1'b1;
    din_data = 8'h11;
    step();
    check("bp_occ1", occupancy, 1);
    check("bp_din_rd1", din_rd, 1);
    din_data = 8'h22;
    step();
    check("bp_occ2", occupancy, 2);
    check("bp_din_rd_full", din_rd, 0);
    check("bp_data11", dout_data, 8'h11);
    din_data = 8'h33;
    step();
    check("bp_hold_occ", occupancy, 2);
    check("bp_hold_data", dout_data, 8'h11);
    dout_rd = 1'b1;
    step();
    check("bp_out22", dout_data, 8'h22);
    check("bp_out22_vld", dout_vld, 1);
    check("bp_occ_after", occupancy, 1);
    step();
    check("bp_out33", dout_data, 8'h33);
    check("bp_out33_vld", dout_vld, 1);
    din_vld = 1'b0;
    step();
    check("bp_empty", occupancy, 0);

    // Asynchronous reset while FULL.
    dout_rd  = 1'b0;
    din_vld  = 1'b1;
    din_data = 8'h5A;
    step();
    din_data = 8'hC3;
    step();
    check("rf_full", occupancy, 2);
    din_vld = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rf_async_occ", occupancy, 0);
    check("rf_async_vld", dout_vld, 0);
    check("rf_async_din_rd", din_rd, 0);
    check("rf_async_data", dout_data, 0);
    step();
    rst_n   = 1'b1;
    dout_rd = 1'b1;
    #1;
    check("rf_release_din_rd", din_rd, 1);
    repeat (3) begin
      step();
      check("rf_no_old_word", dout_vld, 0);
    end
    din_vld  = 1'b1;
    din_data = 8'h77;
    step();
    check("rf_first_vld", dout_vld, 1);
    check("rf_first_data", dout_data, 8'h77);
    din_vld = 1'b0;
    step();
    check("rf_first_drain", occupancy, 0);

    // Random traffic against a queue scoreboard.
    q.delete();
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    words_out  = 0;
    cycles     = 0;
    while (words_out < 10000 && cycles < 60000) begin
      din_vld  = ($urandom_range(0, 3) != 0);
      din_data = 8'($urandom);
      dout_rd  = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_occ", occupancy, q.size());
      check("rnd_vld", dout_vld, (q.size() != 0));
      check("rnd_din_rd", din_rd, (q.size() < 2));
      if (prev_stall) check("rnd_stable", dout_data, prev_data);
      in_fire  = din_vld && din_rd;
      out_fire = dout_vld && dout_rd;
      if (out_fire) begin
        if (q.size() != 0) begin
          check("rnd_data", dout_data, q[0]);
          void'(q.pop_front());
        end
        words_out++;
      end
      if (in_fire) q.push_back(din_data);
      prev_stall = dout_vld && !dout_rd;
      prev_data  = dout_data;
      step();
      cycles++;
    end
    if (words_out < 10000) check("rnd_budget", words_out, 10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
